// File: rtl/segasys1_dlkey.sv
// Download front end: re-times the raw byte stream into a ROM write port, taps the
// 256-byte key window into a key write port and classifies it into a decryption mode.
module segasys1_dlkey #(
  parameter logic [24:0] KEY_BASE = 25'h58400,
  parameter logic [7:0]  SWP_OFS  = 8'h80,
  parameter logic [7:0]  SWP_LIM  = 8'd24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dl_active,
  input  logic        i_dl_wr,
  input  logic [24:0] i_dl_addr,
  input  logic [7:0]  i_dl_data,
  output logic        o_rom_we,
  output logic [24:0] o_rom_ad,
  output logic [7:0]  o_rom_dt,
  output logic        o_key_we,
  output logic [7:0]  o_key_ad,
  output logic [7:0]  o_key_dt,
  output logic [1:0]  o_dec_mode,
  output logic        o_mode_valid,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StEval, StDone} state_e;

  state_e      r_state;
  logic        r_act;
  logic        r_arm;
  logic [8:0]  r_win_cnt;
  logic [8:0]  r_nz_cnt;
  logic [8:0]  r_big_cnt;

  logic [24:0] w_ofs;
  logic        w_in_win;
  logic        w_acc;
  logic        w_key;
  logic        w_rise;
  logic        w_fall;
  logic        w_big;
  logic [1:0]  w_mode;

  // Addresses below the base wrap to huge offsets, so one upper-bits test covers both bounds.
  assign w_ofs    = i_dl_addr - KEY_BASE;
  assign w_in_win = (w_ofs[24:8] == 17'd0);
  assign w_acc    = i_dl_wr && (r_state == StLoad);
  assign w_key    = w_acc && w_in_win;
  assign w_big    = (w_ofs[7:0] >= SWP_OFS) && (i_dl_data >= SWP_LIM);

  // r_arm stays low after reset until dl_active is seen low, so a level held across reset
  // never counts as a fresh session start.
  assign w_rise = i_dl_active && !r_act && r_arm;
  assign w_fall = !i_dl_active && r_act;
  assign o_busy = (r_state == StLoad) || (r_state == StEval);

  always_comb begin
    w_mode = 2'd1;
    if (r_win_cnt == 9'd0 || r_nz_cnt == 9'd0) begin
      w_mode = 2'd0;
    end else if (r_big_cnt == 9'd0) begin
      w_mode = 2'd2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_act        <= 1'b0;
      r_arm        <= 1'b0;
      r_win_cnt    <= 9'd0;
      r_nz_cnt     <= 9'd0;
      r_big_cnt    <= 9'd0;
      o_rom_we     <= 1'b0;
      o_rom_ad     <= 25'd0;
      o_rom_dt     <= 8'd0;
      o_key_we     <= 1'b0;
      o_key_ad     <= 8'd0;
      o_key_dt     <= 8'd0;
      o_dec_mode   <= 2'd0;
      o_mode_valid <= 1'b0;
    end else begin
      r_act    <= i_dl_active;
      if (!i_dl_active) r_arm <= 1'b1;
      o_rom_we <= w_acc;
      o_key_we <= w_key;
      if (w_acc) begin
        o_rom_ad <= i_dl_addr;
        o_rom_dt <= i_dl_data;
      end
      if (w_key) begin
        o_key_ad <= w_ofs[7:0];
        o_key_dt <= i_dl_data;
        if (r_win_cnt != 9'd256) r_win_cnt <= r_win_cnt + 9'd1;
        if (i_dl_data != 8'd0 && r_nz_cnt != 9'd256) r_nz_cnt <= r_nz_cnt + 9'd1;
        if (w_big && r_big_cnt != 9'd256) r_big_cnt <= r_big_cnt + 9'd1;
      end
      unique case (r_state)
        StIdle, StDone: begin
          if (w_rise) begin
            r_state      <= StLoad;
            r_win_cnt    <= 9'd0;
            r_nz_cnt     <= 9'd0;
            r_big_cnt    <= 9'd0;
            o_dec_mode   <= 2'd0;
            o_mode_valid <= 1'b0;
          end
        end
        StLoad: begin
          if (w_fall) r_state <= StEval;
        end
        StEval: begin
          r_state      <= StDone;
          o_dec_mode   <= w_mode;
          o_mode_valid <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_segasys1_dlkey.sv
// Scoreboard bench: the driver queues expected ROM/key writes and mode results, an
// independent negedge monitor pops and compares them whenever the DUT presents output.
module tb_segasys1_dlkey;

  localparam logic [24:0] KeyBase = 25'h58400;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        rom_we;
  logic [24:0] rom_ad;
  logic [7:0]  rom_dt;
  logic        key_we;
  logic [7:0]  key_ad;
  logic [7:0]  key_dt;
  logic [1:0]  dec_mode;
  logic        mode_valid;
  logic        busy;

  segasys1_dlkey dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_dl_active (dl_active),
    .i_dl_wr     (dl_wr),
    .i_dl_addr   (dl_addr),
    .i_dl_data   (dl_data),
    .o_rom_we    (rom_we),
    .o_rom_ad    (rom_ad),
    .o_rom_dt    (rom_dt),
    .o_key_we    (key_we),
    .o_key_ad    (key_ad),
    .o_key_dt    (key_dt),
    .o_dec_mode  (dec_mode),
    .o_mode_valid(mode_valid),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        key;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];
  int   mcyc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rom_cnt = 0;
  int   key_cnt = 0;
  bit   mv_prev = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit in_win(input logic [24:0] a);
    return (a >= KeyBase) && (a <= KeyBase + 25'd255);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_we) begin
        rom_cnt++;
        if (key_we) key_cnt++;
        if (exp_q.size() == 0) begin
          chk("rom_we_unexpected", {7'd0, rom_ad}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rom_ad", {7'd0, rom_ad}, {7'd0, e.addr});
          chk("rom_dt", {24'd0, rom_dt}, {24'd0, e.data});
          chk("rom_latency", cyc, e.cyc);
          chk("key_we", {31'd0, key_we}, {31'd0, e.key});
          if (e.key) begin
            chk("key_ad", {24'd0, key_ad}, {24'd0, e.addr[7:0] - KeyBase[7:0]});
            chk("key_dt", {24'd0, key_dt}, {24'd0, e.data});
          end
        end
      end else if (key_we) begin
        chk("key_we_without_rom_we", 32'd1, 32'd0);
      end
      if (mode_valid && !mv_prev) begin
        if (mode_q.size() == 0) begin
          chk("mode_valid_unexpected", {30'd0, dec_mode}, 32'hFFFF_FFFF);
        end else begin
          chk("dec_mode", {30'd0, dec_mode}, mode_q.pop_front());
          chk("mode_latency", cyc, mcyc_q.pop_front());
        end
      end
      mv_prev = mode_valid;
    end
  end

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (acc) begin
      e.addr = a;
      e.data = d;
      e.key  = in_win(a);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      dl_wr = 1'b0;
    end
  endtask

  task automatic start_session();
    @(posedge clk);
    #1;
    dl_wr     = 1'b0;
    dl_active = 1'b1;
  endtask

  task automatic end_session(input int mode);
    @(posedge clk);
    #1;
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    mode_q.push_back(mode);
    mcyc_q.push_back(cyc + 2);
  endtask

  // Final write coincides with the falling edge of dl_active.
  task automatic wr_fall(input logic [24:0] a, input logic [7:0] d, input int mode);
    wr(a, d, 1'b1);
    dl_active = 1'b0;
    mode_q.push_back(mode);
    mcyc_q.push_back(cyc + 2);
  endtask

  task automatic key_image(input int variant);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      if (i < 128) v = 8'hA5;
      else         v = 8'((i - 128) % 24);
      if (i == 8'hC3 && variant == 1) v = 8'd24;
      if (i == 8'hC3 && variant == 2) v = 8'hFF;
      wr(KeyBase + 25'(i), v, 1'b1);
    end
  endtask

  int k0;
  int r0;

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = 25'd0;
    dl_data   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    dl_active = 1'b1;  // rises while reset is still asserted: edge must be lost
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("reset_rom_we", {31'd0, rom_we}, 32'd0);
    chk("reset_rom_ad", {7'd0, rom_ad}, 32'd0);
    chk("reset_key_we", {31'd0, key_we}, 32'd0);
    chk("reset_dec_mode", {30'd0, dec_mode}, 32'd0);
    chk("reset_mode_valid", {31'd0, mode_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) wr(KeyBase + 25'(i), 8'h11, 1'b0);
    idle(1);
    chk("held_active_not_busy", {31'd0, busy}, 32'd0);
    dl_active = 1'b0;
    idle(3);

    // Plain: all-zero key
    k0 = key_cnt;
    start_session();
    for (int i = 0; i < 256; i++) begin
      wr(KeyBase + 25'(i), 8'h00, 1'b1);
      if (i == 3) chk("busy_in_load", {31'd0, busy}, 32'd1);
    end
    end_session(0);
    idle(4);
    chk("plain_key_pulses", key_cnt - k0, 256);
    chk("done_not_busy", {31'd0, busy}, 32'd0);

    // Type 2, then type 1 with two kinds of illegal index
    start_session();
    key_image(0);
    wr(KeyBase + 25'd256, 8'h42, 1'b1);  // just past the window: ROM only
    end_session(2);
    idle(4);
    start_session();
    key_image(1);
    end_session(1);
    idle(4);
    start_session();
    key_image(2);
    end_session(1);
    idle(4);

    // No key window in image; writes in DONE are dropped
    for (int i = 0; i < 3; i++) wr(25'h100 + 25'(i), 8'h99, 1'b0);
    idle(2);
    k0 = key_cnt;
    r0 = rom_cnt;
    start_session();
    for (int i = 0; i < 32768; i++) wr(25'(i), 8'(i) ^ 8'h5A, 1'b1);
    end_session(0);
    idle(4);
    chk("nowin_key_pulses", key_cnt - k0, 0);
    chk("nowin_rom_pulses", rom_cnt - r0, 32768);

    // Write on the falling edge counts; a write in EVAL is dropped
    start_session();
    idle(2);
    wr_fall(KeyBase + 25'h90, 8'h03, 2);
    wr(KeyBase + 25'h10, 8'h77, 1'b0);
    idle(4);

    // Reset mid-load abandons the session
    start_session();
    for (int i = 0; i < 100; i++) wr(KeyBase + 25'(i), 8'(i + 1), 1'b1);
    @(posedge clk);
    #1;
    dl_wr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 100; i < 120; i++) wr(KeyBase + 25'(i), 8'hEE, 1'b0);
    idle(1);
    chk("abandoned_mode_valid", {31'd0, mode_valid}, 32'd0);
    chk("abandoned_busy", {31'd0, busy}, 32'd0);
    dl_active = 1'b0;
    idle(3);
    chk("abandoned_mode_valid_after_fall", {31'd0, mode_valid}, 32'd0);
    start_session();
    for (int i = 0; i < 256; i++) wr(KeyBase + 25'(i), 8'h00, 1'b1);
    end_session(0);
    idle(5);

    chk("rom_queue_drained", exp_q.size(), 0);
    chk("mode_queue_drained", mode_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
